// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sub_bytes_seq
//  Purpose  : Sequential AES InvSubBytes stage. A 128-bit state is captured
//             over a valid/ready handshake, its 16 bytes are pushed through
//             LANES inverse S-box lookups (LANES bytes per cycle), and the
//             substituted state is returned over a valid/ready handshake.
//  Ports    : clk, rst_n (async active-low), flush (sync abort)
//             in_valid / in_ready / in_state[127:0]    - input handshake
//             out_valid / out_ready / out_state[127:0] - output handshake
//             busy                                     - BUSY or DONE
//             Byte k of a state is bits [127-8k -: 8] (column-major).
//  Macro    : INV_SUB_SHIFT_ROWS_EN - fuse InvShiftRows on the output wiring.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NBEATS = 16 / LANES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BW     = 8 * LANES;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [127:0]    cap_q,   cap_d;
  logic [127:0]    res_q,   res_d;
  logic [BW-1:0]   w_beat_in;
  logic [BW-1:0]   w_beat_out;

  // One beat of the captured state, selected by the counter.
  always_comb begin
    w_beat_in = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (cnt_q == CW'(b)) w_beat_in = cap_q[127 - b*BW -: BW];
    end
  end

  // Lane l handles byte cnt*LANES+l, i.e. the l-th byte from the top of the beat.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_beat_out[BW-1-8*l -: 8] = inv_sbox(w_beat_in[BW-1-8*l -: 8]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cap_d   = in_state;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          for (int b = 0; b < NBEATS; b++) begin
            if (cnt_q == CW'(b)) res_d[127 - b*BW -: BW] = w_beat_out;
          end
          if (cnt_q == CW'(NBEATS - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);

`ifdef INV_SUB_SHIFT_ROWS_EN
  // Row r is rotated right by r columns: out(r,c) = sub(r, (c-r) mod 4).
  generate
    for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
        localparam int DST = r + 4*c;
        localparam int SRC = r + 4*((c - r + 4) % 4);
        assign out_state[127-8*DST -: 8] = res_q[127-8*SRC -: 8];
      end
    end
  endgenerate
`else
  assign out_state = res_q;
`endif

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Sequential InvSubBytes stage for the AES decryption datapath.
- Accepts a 128-bit cipher state over a valid/ready handshake and streams its 16 bytes through LANES instances of the existing inverse S-box byte lookup, LANES bytes per cycle.
- Returns the substituted 128-bit state over a valid/ready handshake.
- Sits between AddRoundKey/InvMixColumns (upstream) and the round register (downstream).

Parameters:
- LANES, 1, number of inverse S-box instances used in parallel; legal values 1, 2, 4, 8, 16. Any other value is an elaboration error.
- NBEATS, 16/LANES, derived localparam (not overridable); number of processing cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  input state valid
- in_ready  output  1  block can accept a state
- in_state  input  128  input state; byte k = in_state[127-8k -: 8], FIPS-197 column-major (row k%4, column k/4)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_state  output  128  substituted state, same byte ordering as in_state
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; beat counter is 0.
  - Capture and result registers are 0.
  - Outputs: in_ready=1, out_valid=0, out_state=0, busy=0.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready, in_state is captured, the counter is set to 0, and the FSM moves to BUSY.
  - BUSY: in_ready=0. Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the captured state pass through the lanes, and the results are written to the same byte positions of the result register. The counter then increments. When cnt==NBEATS-1, the FSM moves to DONE and the counter wraps to 0.
  - DONE: out_valid=1, out_state=result register, held stable until out_ready. When out_valid&&out_ready, the FSM moves to IDLE.
- Latency: with the handshake in cycle 0, out_valid is first high in cycle NBEATS+1 (17 for LANES=1, 2 for LANES=16).
- Throughput: at most one block per NBEATS+2 cycles. No input is accepted in the same cycle that the output is taken.
- Backpressure: DONE may persist for any number of cycles. out_state must not change while out_valid=1 and out_ready=0.
- in_valid is ignored outside IDLE, and in_state is sampled only on the handshake cycle.
- flush (synchronous, highest priority after reset):
  - Next cycle the FSM is in IDLE with the counter at 0 and out_valid=0.
  - The result register is not cleared. out_state is don't-care while out_valid=0.
  - flush in IDLE together with in_valid: the flush wins and no capture occurs.
- Reset asserted mid-block: the block is discarded immediately and the outputs return to their reset values asynchronously.
- Lookup: each lane is a combinational 8-bit inverse S-box. No arithmetic widening; the counter width is clog2(NBEATS), minimum 1 bit.

Optional Feature:
- Macro INV_SUB_SHIFT_ROWS_EN.
- Defined: InvShiftRows is fused on the output path. out_state byte (r + 4c) = substituted byte (r + 4*((c - r) mod 4)), for r, c in 0..3. This is pure wiring after the result register, so latency is unchanged.
- Undefined: out_state is the plain substituted state with byte positions preserved.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, out_state=0.
- Known vector, LANES=1, macro off: in_state=128'h00_63_FF_53_7C_ED_00_00_00_00_00_00_00_00_00_00 -> after 17 cycles out_state=128'h52_00_7D_50_01_53_52_52_52_52_52_52_52_52_52_52, out_valid=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0. Raise out_ready -> out_valid drops next cycle and in_ready=1.
- Flush: assert flush in BUSY at beat 5 -> IDLE next cycle, out_valid never asserted. A following block with in_state all 8'h63 -> out_state all 8'h00.
- LANES=16, macro on: in_state = bytes k=0..15 set to 8'h00..8'h0F in order -> out_valid in cycle 2. Each output byte (r+4c) equals InvS(byte r+4*((c-r) mod 4)); for example, out byte 1 = InvS(8'h0D) = 8'hF3.
- Async reset mid-block: drop rst_n during BUSY beat 3 -> out_valid=0 and in_ready=1 without waiting for a clock edge.
